// File: rtl/alarm_controller_if.sv
// Signal bundle between the alarm controller and its surroundings
// (switch synchronisers, countdown timer, siren and display logic).
interface alarm_controller_if;
  logic       ignition;
  logic       door_driver;
  logic       door_pass;
  logic       reprogram;
  logic [1:0] time_param_sel;
  logic [3:0] time_value;
  logic       expired;
  logic       one_hz_enable;
  logic       start_timer;
  logic [3:0] value;
  logic       siren;
  logic       status_led;
  logic [2:0] fsm_state;

  modport master (
    output ignition, door_driver, door_pass, reprogram, time_param_sel,
           time_value, expired, one_hz_enable,
    input  start_timer, value, siren, status_led, fsm_state
  );

  modport slave (
    input  ignition, door_driver, door_pass, reprogram, time_param_sel,
           time_value, expired, one_hz_enable,
    output start_timer, value, siren, status_led, fsm_state
  );
endinterface

// File: rtl/alarm_controller.sv
// Car alarm controller: arms/triggers/sounds based on ignition and doors,
// drives the countdown timer and holds the programmable delay table.
module alarm_controller #(
  parameter logic [3:0] T_ARM_DEF   = 4'd6,
  parameter logic [3:0] T_DRV_DEF   = 4'd8,
  parameter logic [3:0] T_PASS_DEF  = 4'd15,
  parameter logic [3:0] T_ALARM_DEF = 4'd10
) (
  input logic               clock,
  input logic               reset,
  alarm_controller_if.slave bus
);

  typedef enum logic [2:0] {
    ST_ARMED      = 3'd0,
    ST_TRIGGERED  = 3'd1,
    ST_SOUND      = 3'd2,
    ST_DISARMED   = 3'd3,
    ST_WAIT_OPEN  = 3'd4,
    ST_WAIT_CLOSE = 3'd5,
    ST_ARM_DELAY  = 3'd6
  } state_e;

  localparam logic [1:0] SEL_ARM   = 2'd0;
  localparam logic [1:0] SEL_DRV   = 2'd1;
  localparam logic [1:0] SEL_PASS  = 2'd2;
  localparam logic [1:0] SEL_ALARM = 2'd3;

  function automatic logic [3:0] clamp_time(input logic [3:0] v);
    return (v == 4'd0) ? 4'd1 : v;
  endfunction

  state_e          state_q, state_d;
  logic            start_q, start_d;
  logic            start_dly_q;
  logic [3:0]      value_q, value_d;
  logic            siren_q, siren_d;
  logic [3:0][3:0] tbl_q, tbl_d;
  logic            exp_ok_s;
  logic            led_s;

  // An expired pulse cannot belong to a countdown started this cycle or last cycle.
  assign exp_ok_s = bus.expired & ~start_q & ~start_dly_q;

  // Next-state, timer-load and table-write decision.
  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    value_d = value_q;
    tbl_d   = tbl_q;
    if (bus.reprogram) begin
      tbl_d[bus.time_param_sel] = clamp_time(bus.time_value);
      state_d = ST_ARMED;
    end else if (bus.ignition) begin
      state_d = ST_DISARMED;
    end else begin
      case (state_q)
        ST_ARMED: begin
          if (bus.door_driver) begin
            state_d = ST_TRIGGERED;
            start_d = 1'b1;
            value_d = tbl_q[SEL_DRV];
          end else if (bus.door_pass) begin
            state_d = ST_TRIGGERED;
            start_d = 1'b1;
            value_d = tbl_q[SEL_PASS];
          end else begin
            state_d = ST_ARMED;
          end
        end
        ST_TRIGGERED: begin
          if (exp_ok_s) begin
            state_d = ST_SOUND;
            start_d = 1'b1;
            value_d = tbl_q[SEL_ALARM];
          end else begin
            state_d = ST_TRIGGERED;
          end
        end
        ST_SOUND: begin
          if (exp_ok_s && (bus.door_driver || bus.door_pass)) begin
            start_d = 1'b1;
            value_d = tbl_q[SEL_ALARM];
          end else if (exp_ok_s) begin
            state_d = ST_ARMED;
          end else begin
            state_d = ST_SOUND;
          end
        end
        ST_DISARMED:  state_d = ST_WAIT_OPEN;
        ST_WAIT_OPEN: begin
          if (bus.door_driver) state_d = ST_WAIT_CLOSE;
          else                 state_d = ST_WAIT_OPEN;
        end
        ST_WAIT_CLOSE: begin
          if (!bus.door_driver) begin
            state_d = ST_ARM_DELAY;
            start_d = 1'b1;
            value_d = tbl_q[SEL_ARM];
          end else begin
            state_d = ST_WAIT_CLOSE;
          end
        end
        ST_ARM_DELAY: begin
          if (bus.door_driver) state_d = ST_WAIT_CLOSE;
          else if (exp_ok_s)   state_d = ST_ARMED;
          else                 state_d = ST_ARM_DELAY;
        end
        default: state_d = ST_ARMED;
      endcase
    end
    siren_d = (state_d == ST_SOUND);
  end

  // State, timer handshake, siren and delay-table registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_ARMED;
      start_q     <= 1'b0;
      start_dly_q <= 1'b0;
      value_q     <= 4'd0;
      siren_q     <= 1'b0;
      tbl_q       <= {T_ALARM_DEF, T_PASS_DEF, T_DRV_DEF, T_ARM_DEF};
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      start_dly_q <= start_q;
      value_q     <= value_d;
      siren_q     <= siren_d;
      tbl_q       <= tbl_d;
    end
  end

  // Indicator: blinks while armed, solid while an intrusion is in progress.
  always_comb begin
    case (state_q)
      ST_ARMED:     led_s = bus.one_hz_enable;
      ST_TRIGGERED: led_s = 1'b1;
      ST_SOUND:     led_s = 1'b1;
      default:      led_s = 1'b0;
    endcase
  end

  assign bus.start_timer = start_q;
  assign bus.value       = value_q;
  assign bus.siren       = siren_q;
  assign bus.status_led  = led_s;
  assign bus.fsm_state   = state_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Self-checking bench for alarm_controller: directed vector table, a reset
// sequence mid-SOUND, then random stimulus against a behavioural model.
module tb_alarm_controller;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  alarm_controller_if bus ();

  alarm_controller dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       ign, dd, dp, ex, rep, hz;
    logic [1:0] sel;
    logic [3:0] tv;
    int         e_state, e_start, e_value, e_siren;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int ign, dd, dp, ex, rep, sel, tv, st, sta, val, sir);
    vec_t v;
    v.ign = ign[0]; v.dd = dd[0]; v.dp = dp[0]; v.ex = ex[0]; v.rep = rep[0];
    v.sel = sel[1:0]; v.tv = tv[3:0]; v.hz = 1'($urandom_range(0, 1));
    v.e_state = st; v.e_start = sta; v.e_value = val; v.e_siren = sir;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int ign, dd, dp, ex, rep, sel, tv, hz);
    bus.ignition = ign[0]; bus.door_driver = dd[0]; bus.door_pass = dp[0];
    bus.expired = ex[0]; bus.reprogram = rep[0]; bus.time_param_sel = sel[1:0];
    bus.time_value = tv[3:0]; bus.one_hz_enable = hz[0];
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int led_of(input int st, input logic hz);
    if (st == 0) return int'(hz);
    if (st == 1 || st == 2) return 1;
    return 0;
  endfunction

  task automatic chk_out(input string tag, input int st, sta, val, sir);
    chk({tag, ".state"}, int'(bus.fsm_state), st);
    chk({tag, ".start"}, int'(bus.start_timer), sta);
    chk({tag, ".value"}, int'(bus.value), val);
    chk({tag, ".siren"}, int'(bus.siren), sir);
    chk({tag, ".led"}, int'(bus.status_led), led_of(st, bus.one_hz_enable));
  endtask

  // Behavioural reference: delays by table slot, expiry honoured only
  // when at least two cycles have passed since the last timer start.
  int m_state, m_start, m_value, m_siren, m_cyc, m_last;
  int m_tbl[4];

  task automatic model_reset();
    m_state = 0; m_start = 0; m_value = 0; m_siren = 0;
    m_cyc = 0; m_last = -10;
    m_tbl[0] = 6; m_tbl[1] = 8; m_tbl[2] = 15; m_tbl[3] = 10;
  endtask

  task automatic model_edge();
    int  ns, slot;
    bit  ok, doors;
    ns = m_state; slot = -1;
    ok = bus.expired && (m_cyc > m_last + 1);
    doors = bus.door_driver || bus.door_pass;
    if (bus.reprogram) begin
      m_tbl[bus.time_param_sel] = (bus.time_value == 4'd0) ? 1 : int'(bus.time_value);
      ns = 0;
    end else if (bus.ignition) ns = 3;
    else if (m_state == 0 && bus.door_driver) begin ns = 1; slot = 1; end
    else if (m_state == 0 && bus.door_pass) begin ns = 1; slot = 2; end
    else if (m_state == 1 && ok) begin ns = 2; slot = 3; end
    else if (m_state == 2 && ok) begin
      if (doors) slot = 3; else ns = 0;
    end
    else if (m_state == 3) ns = 4;
    else if (m_state == 4 && bus.door_driver) ns = 5;
    else if (m_state == 5 && !bus.door_driver) begin ns = 6; slot = 0; end
    else if (m_state == 6 && bus.door_driver) ns = 5;
    else if (m_state == 6 && ok) ns = 0;
    m_cyc++;
    m_state = ns;
    m_siren = (ns == 2) ? 1 : 0;
    m_start = (slot >= 0) ? 1 : 0;
    if (slot >= 0) begin
      m_value = m_tbl[slot];
      m_last = m_cyc;
    end
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    // ign dd dp ex rep sel tv | state start value siren
    add(0,0,0,0,0,0,0, 0,0,0,0);
    add(0,1,0,0,0,0,0, 1,1,8,0);
    add(0,1,0,0,0,0,0, 1,0,8,0);
    add(0,1,0,1,0,0,0, 1,0,8,0);   // expiry right after a start is stale
    add(0,1,0,1,0,0,0, 2,1,10,1);
    add(0,1,0,0,0,0,0, 2,0,10,1);
    add(0,1,0,0,0,0,0, 2,0,10,1);
    add(0,1,0,1,0,0,0, 2,1,10,1);
    add(0,0,0,0,0,0,0, 2,0,10,1);
    add(0,0,0,0,0,0,0, 2,0,10,1);
    add(0,0,0,1,0,0,0, 0,0,10,0);
    add(0,0,1,0,0,0,0, 1,1,15,0);
    add(1,0,0,0,0,0,0, 3,0,15,0);
    add(0,0,0,0,0,0,0, 4,0,15,0);
    add(0,1,0,0,0,0,0, 5,0,15,0);
    add(0,0,0,0,0,0,0, 6,1,6,0);
    add(0,0,0,0,0,0,0, 6,0,6,0);
    add(0,0,0,0,0,0,0, 6,0,6,0);
    add(0,0,0,1,0,0,0, 0,0,6,0);
    add(0,1,1,0,0,0,0, 1,1,8,0);
    add(0,0,0,0,0,0,0, 1,0,8,0);
    add(0,0,0,0,0,0,0, 1,0,8,0);
    add(0,0,0,1,0,0,0, 2,1,10,1);
    add(1,0,0,0,0,0,0, 3,0,10,0);
    add(0,0,0,0,0,0,0, 4,0,10,0);
    add(0,1,0,0,0,0,0, 5,0,10,0);
    add(0,0,0,0,0,0,0, 6,1,6,0);
    add(0,0,0,0,0,0,0, 6,0,6,0);
    add(0,1,0,0,0,0,0, 5,0,6,0);
    add(0,1,0,1,0,0,0, 5,0,6,0);
    add(0,0,0,1,0,0,0, 6,1,6,0);
    add(0,0,0,1,0,0,0, 6,0,6,0);
    add(0,0,0,1,0,0,0, 6,0,6,0);
    add(0,0,0,1,0,0,0, 0,0,6,0);
    add(0,1,0,0,0,0,0, 1,1,8,0);
    add(0,1,0,1,1,1,3, 0,0,8,0);   // reprogram beats door and expiry
    add(0,1,0,0,0,0,0, 1,1,3,0);
    add(0,0,0,0,1,1,0, 0,0,3,0);
    add(0,1,0,0,0,0,0, 1,1,1,0);
    add(0,0,0,0,0,0,0, 1,0,1,0);
    add(0,0,0,0,0,0,0, 1,0,1,0);
    add(0,1,0,1,0,0,0, 2,1,10,1);

    tick();
    tick();
    chk_out("reset", 0, 0, 0, 0);
    reset = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].ign, vecs[i].dd, vecs[i].dp, vecs[i].ex, vecs[i].rep,
            vecs[i].sel, vecs[i].tv, vecs[i].hz);
      tick();
      chk_out($sformatf("vec%0d", i), vecs[i].e_state, vecs[i].e_start,
              vecs[i].e_value, vecs[i].e_siren);
    end

    // Reset asserted asynchronously while sounding, then released.
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    tick();
    chk_out("pre_rst", 2, 0, 10, 1);
    #2 reset = 1'b0;
    #1 chk_out("async_rst", 0, 0, 0, 0);
    tick();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_out("post_rst", 0, 0, 0, 0);
    end
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    tick();
    chk_out("default_drv", 1, 1, 8, 0);

    // Random stimulus against the reference model.
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    reset = 1'b1;
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 19) == 0) ? 1 : 0,
            ($urandom_range(0, 2) == 0) ? 1 : 0,
            ($urandom_range(0, 2) == 0) ? 1 : 0,
            ($urandom_range(0, 3) == 0) ? 1 : 0,
            ($urandom_range(0, 39) == 0) ? 1 : 0,
            int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 1)));
      @(posedge clock);
      model_edge();
      #1;
      chk_out($sformatf("rnd%0d", n), m_state, m_start, m_value, m_siren);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
